// File: rtl/sc_regbank_pkg.sv
// Shared types and default widths for the SC_REGGENERAL bank write-port controller.
package sc_regbank_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_NREGS     = 8;
  localparam int DEF_ADDRWIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2,
    CLR   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_sel_t;

endpackage

// File: rtl/sc_regbank_decoder.sv
// Register index to active-low one-hot strobe vector; indices >= NREGS select nothing.
module sc_regbank_decoder #(
  parameter int NREGS     = 8,
  parameter int ADDRWIDTH = 3
) (
  input  logic                 en,
  input  logic [ADDRWIDTH-1:0] idx,
  output logic [NREGS-1:0]     vec_n
);

  // Drive the single selected bit low when enabled.
  always_comb begin
    // NOTE: every output bit gets a default before the conditional writes, so no latch is inferred.
    vec_n = '1;
    for (int i = 0; i < NREGS; i++) begin
      if (en && (int'(idx) == i)) vec_n[i] = 1'b0;
    end
  end

endmodule

// File: rtl/sc_regbank_arbiter.sv
// Write-port controller: round-robin arbitration of two requesters onto the register
// bank plus a bank-wide clear sweep. All outputs come straight from flops.
module sc_regbank_arbiter
  import sc_regbank_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NREGS     = DEF_NREGS,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH
) (
  input  logic                 SC_REGGENERAL_CLOCK_50,
  input  logic                 SC_REGGENERAL_RESET_InLow,
  input  logic                 reqA_req,
  input  logic [ADDRWIDTH-1:0] reqA_addr,
  input  logic [DATAWIDTH-1:0] reqA_data,
  output logic                 reqA_ack,
  input  logic                 reqB_req,
  input  logic [ADDRWIDTH-1:0] reqB_addr,
  input  logic [DATAWIDTH-1:0] reqB_data,
  output logic                 reqB_ack,
  input  logic                 clrAll_start,
  output logic                 clrAll_busy,
  output logic [NREGS-1:0]     bank_load_InLow,
  output logic [NREGS-1:0]     bank_clear_InLow,
  output logic [DATAWIDTH-1:0] bank_data_OutBUS
);

  localparam logic [ADDRWIDTH-1:0] LAST_IDX = ADDRWIDTH'(NREGS - 1);

  state_t                 state_q, state_d;
  req_sel_t               ptr_q, ptr_d;
  logic [ADDRWIDTH-1:0]   cnt_q, cnt_d;
  logic [DATAWIDTH-1:0]   data_q, data_d;
  logic [NREGS-1:0]       load_q, load_d;
  logic [NREGS-1:0]       clear_q, clear_d;
  logic                   ack_a_q, ack_a_d;
  logic                   ack_b_q, ack_b_d;
  logic                   busy_q, busy_d;

  logic                   ld_en, clr_en;
  logic [ADDRWIDTH-1:0]   ld_idx, clr_idx;
  req_sel_t               gsel;
  logic                   grant;

  // Strobe decoders: the grant address and the sweep index are decoded one cycle
  // ahead and registered, so the strobes leave the block glitch-free.
  sc_regbank_decoder #(.NREGS(NREGS), .ADDRWIDTH(ADDRWIDTH)) u_load_dec (
    .en    (ld_en),
    .idx   (ld_idx),
    .vec_n (load_d)
  );

  sc_regbank_decoder #(.NREGS(NREGS), .ADDRWIDTH(ADDRWIDTH)) u_clear_dec (
    .en    (clr_en),
    .idx   (clr_idx),
    .vec_n (clear_d)
  );

  // Requester selection: round-robin pointer breaks ties, otherwise the lone requester wins.
  always_comb begin
    grant = reqA_req | reqB_req;
    if (reqA_req && reqB_req) gsel = ptr_q;
    else if (reqA_req)        gsel = REQ_A;
    else                      gsel = REQ_B;
  end

  // Next-state and next-output logic for the arbitration / sweep FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    busy_d  = 1'b0;
    ld_en   = 1'b0;
    ld_idx  = (gsel == REQ_A) ? reqA_addr : reqB_addr;
    clr_en  = 1'b0;
    clr_idx = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (clrAll_start) begin
          state_d = CLR;
          cnt_d   = '0;
          clr_en  = 1'b1;
          clr_idx = '0;
          busy_d  = 1'b1;
        end else if (grant) begin
          // Address and data are captured here, into the strobe and bus flops.
          state_d = (gsel == REQ_A) ? GNT_A : GNT_B;
          ld_en   = 1'b1;
          data_d  = (gsel == REQ_A) ? reqA_data : reqB_data;
          ack_a_d = (gsel == REQ_A);
          ack_b_d = (gsel == REQ_B);
        end
      end
      GNT_A: begin
        state_d = IDLE;
        ptr_d   = REQ_B;
      end
      GNT_B: begin
        state_d = IDLE;
        ptr_d   = REQ_A;
      end
      CLR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + ADDRWIDTH'(1);
          clr_en  = 1'b1;
          clr_idx = cnt_q + ADDRWIDTH'(1);
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, sweep counter and registered outputs.
  always_ff @(posedge SC_REGGENERAL_CLOCK_50 or negedge SC_REGGENERAL_RESET_InLow) begin
    if (!SC_REGGENERAL_RESET_InLow) begin
      state_q <= IDLE;
      ptr_q   <= REQ_A;
      cnt_q   <= '0;
      data_q  <= '0;
      load_q  <= '1;
      clear_q <= '1;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      load_q  <= load_d;
      clear_q <= clear_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      busy_q  <= busy_d;
    end
  end

  assign reqA_ack         = ack_a_q;
  assign reqB_ack         = ack_b_q;
  assign clrAll_busy      = busy_q;
  assign bank_load_InLow  = load_q;
  assign bank_clear_InLow = clear_q;
  assign bank_data_OutBUS = data_q;

endmodule

// File: tb/tb_sc_regbank_arbiter.sv
// Self-checking bench: reset, vector table, directed multi-cycle sequences, and a
// randomized run against a transaction-level reference model. Two instances:
// u8 (NREGS=8) and u6 (NREGS=6, so indices 6 and 7 are out of range).
module tb_sc_regbank_arbiter;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic             rst_n;
  logic [1:0]       a_req, b_req, start;
  logic [1:0][2:0]  a_addr, b_addr;
  logic [1:0][7:0]  a_data, b_data;
  logic [1:0]       ack_a, ack_b, busy;
  logic [1:0][7:0]  dbus;
  logic [7:0]       ld8, clr8;
  logic [5:0]       ld6, clr6;

  sc_regbank_arbiter u8 (
    .SC_REGGENERAL_CLOCK_50(clk), .SC_REGGENERAL_RESET_InLow(rst_n),
    .reqA_req(a_req[0]), .reqA_addr(a_addr[0]), .reqA_data(a_data[0]), .reqA_ack(ack_a[0]),
    .reqB_req(b_req[0]), .reqB_addr(b_addr[0]), .reqB_data(b_data[0]), .reqB_ack(ack_b[0]),
    .clrAll_start(start[0]), .clrAll_busy(busy[0]),
    .bank_load_InLow(ld8), .bank_clear_InLow(clr8), .bank_data_OutBUS(dbus[0])
  );

  sc_regbank_arbiter #(.DATAWIDTH(8), .NREGS(6), .ADDRWIDTH(3)) u6 (
    .SC_REGGENERAL_CLOCK_50(clk), .SC_REGGENERAL_RESET_InLow(rst_n),
    .reqA_req(a_req[1]), .reqA_addr(a_addr[1]), .reqA_data(a_data[1]), .reqA_ack(ack_a[1]),
    .reqB_req(b_req[1]), .reqB_addr(b_addr[1]), .reqB_data(b_data[1]), .reqB_ack(ack_b[1]),
    .clrAll_start(start[1]), .clrAll_busy(busy[1]),
    .bank_load_InLow(ld6), .bank_clear_InLow(clr6), .bank_data_OutBUS(dbus[1])
  );

  // Behavioural register bank driven by the strobes (clear dominates load).
  logic       bank_wr_all;
  logic [7:0] bank_fill;
  logic [7:0] bank0 [8];
  logic [7:0] bank1 [6];

  always @(posedge clk) begin
    for (int r = 0; r < 8; r++) begin
      if (bank_wr_all)   bank0[r] <= bank_fill;
      else if (!clr8[r]) bank0[r] <= 8'h00;
      else if (!ld8[r])  bank0[r] <= dbus[0];
    end
  end

  always @(posedge clk) begin
    for (int r = 0; r < 6; r++) begin
      if (bank_wr_all)   bank1[r] <= bank_fill;
      else if (!clr6[r]) bank1[r] <= 8'h00;
      else if (!ld6[r])  bank1[r] <= dbus[1];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nregs(input int i);
    return (i == 0) ? 8 : 6;
  endfunction

  function automatic logic [31:0] ldv(input int i);
    return (i == 0) ? {24'h0, ld8} : {26'h0, ld6};
  endfunction

  function automatic logic [31:0] clrv(input int i);
    return (i == 0) ? {24'h0, clr8} : {26'h0, clr6};
  endfunction

  // All-ones over n bits with bit idx low (idx < 0 or >= n: no bit low).
  function automatic logic [31:0] exp_vec(input int n, input int idx);
    logic [31:0] v;
    v = (32'h1 << n) - 32'h1;
    if (idx >= 0 && idx < n) v[idx] = 1'b0;
    return v;
  endfunction

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_u%0d_load", tag, i), ldv(i), exp_vec(nregs(i), -1));
      check($sformatf("%s_u%0d_clear", tag, i), clrv(i), exp_vec(nregs(i), -1));
      check($sformatf("%s_u%0d_data", tag, i), 32'(dbus[i]), 32'h0);
      check($sformatf("%s_u%0d_acks", tag, i), {30'h0, ack_a[i], ack_b[i]}, 32'h0);
      check($sformatf("%s_u%0d_busy", tag, i), 32'(busy[i]), 32'h0);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // mode: 0 waiting, 1 one-cycle write in flight, 2 sweeping (m_k = register being cleared)
  int m_mode [2], m_k [2], m_rr [2], m_last [2];
  int e_ld [2], e_clr [2], e_data [2], e_ack_a [2], e_ack_b [2], e_busy [2];
  int exp_bank [2][8];

  task automatic mreset(input int i);
    m_mode[i] = 0; m_k[i] = 0; m_rr[i] = 0; m_last[i] = 0;
    e_ld[i] = -1; e_clr[i] = -1; e_data[i] = 0;
    e_ack_a[i] = 0; e_ack_b[i] = 0; e_busy[i] = 0;
  endtask

  // Predict the outputs of the cycle after the coming edge from the current inputs.
  task automatic mstep(input int i);
    int n, who, addr;
    n = nregs(i);
    e_ack_a[i] = 0; e_ack_b[i] = 0; e_ld[i] = -1; e_clr[i] = -1; e_busy[i] = 0;
    if (m_mode[i] == 2) begin
      m_k[i]++;
      if (m_k[i] >= n) m_mode[i] = 0;
      else begin e_clr[i] = m_k[i]; e_busy[i] = 1; end
    end else if (m_mode[i] == 1) begin
      m_mode[i] = 0;
      m_rr[i]   = 1 - m_last[i];
    end else if (start[i]) begin
      m_mode[i] = 2; m_k[i] = 0; e_clr[i] = 0; e_busy[i] = 1;
    end else if (a_req[i] || b_req[i]) begin
      who       = (a_req[i] && b_req[i]) ? m_rr[i] : (a_req[i] ? 0 : 1);
      m_last[i] = who;
      m_mode[i] = 1;
      addr      = (who == 0) ? int'(a_addr[i]) : int'(b_addr[i]);
      e_data[i] = (who == 0) ? int'(a_data[i]) : int'(b_data[i]);
      if (addr < n) e_ld[i] = addr;
      if (who == 0) e_ack_a[i] = 1; else e_ack_b[i] = 1;
    end
  endtask

  task automatic rcycle();
    for (int i = 0; i < 2; i++) mstep(i);
    tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rnd_u%0d_load", i), ldv(i), exp_vec(nregs(i), e_ld[i]));
      check($sformatf("rnd_u%0d_clear", i), clrv(i), exp_vec(nregs(i), e_clr[i]));
      check($sformatf("rnd_u%0d_ack_a", i), 32'(ack_a[i]), 32'(e_ack_a[i]));
      check($sformatf("rnd_u%0d_ack_b", i), 32'(ack_b[i]), 32'(e_ack_b[i]));
      check($sformatf("rnd_u%0d_busy", i), 32'(busy[i]), 32'(e_busy[i]));
      if (e_ack_a[i] != 0 || e_ack_b[i] != 0)
        check($sformatf("rnd_u%0d_data", i), 32'(dbus[i]), 32'(e_data[i]));
      if (e_clr[i] >= 0)     exp_bank[i][e_clr[i]] = 0;
      else if (e_ld[i] >= 0) exp_bank[i][e_ld[i]]  = e_data[i];
      // Requesters hold until ack, then may immediately post a new write.
      if (ack_a[i]) begin
        a_req[i] = 1'($urandom_range(0, 1));
        a_addr[i] = 3'($urandom_range(0, 7)); a_data[i] = 8'($urandom_range(0, 255));
      end else if (!a_req[i] && $urandom_range(0, 3) == 0) begin
        a_req[i] = 1'b1;
        a_addr[i] = 3'($urandom_range(0, 7)); a_data[i] = 8'($urandom_range(0, 255));
      end
      if (ack_b[i]) begin
        b_req[i] = 1'($urandom_range(0, 1));
        b_addr[i] = 3'($urandom_range(0, 7)); b_data[i] = 8'($urandom_range(0, 255));
      end else if (!b_req[i] && $urandom_range(0, 3) == 0) begin
        b_req[i] = 1'b1;
        b_addr[i] = 3'($urandom_range(0, 7)); b_data[i] = 8'($urandom_range(0, 255));
      end
      start[i] = ($urandom_range(0, 39) == 0);
    end
  endtask

  task automatic drop_inputs();
    a_req = '0; b_req = '0; start = '0;
  endtask

  // ---------------- vector table (instance u8, starts from reset) ----------------
  typedef struct {
    logic       start;
    logic       a_req;  logic [2:0] a_addr; logic [7:0] a_data;
    logic       b_req;  logic [2:0] b_addr; logic [7:0] b_data;
    logic [7:0] ld;     logic [7:0] clr;
    logic       busy;   logic ack_a; logic ack_b;
    logic [7:0] data;   logic chk_data;
    int         settle;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach its end, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; drop_inputs();
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    bank_wr_all = 1'b0; bank_fill = 8'h00;

    tbl[0] = '{1'b0, 1'b1, 3'd2, 8'hA5, 1'b0, 3'd0, 8'h00, 8'hFB, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1};
    tbl[1] = '{1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 3'd6, 8'h66, 8'hBF, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1};
    tbl[2] = '{1'b0, 1'b1, 3'd3, 8'h33, 1'b1, 3'd4, 8'h44, 8'hF7, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1};
    tbl[3] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h0F, 8'hFE, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b1, 1};
    tbl[4] = '{1'b1, 1'b1, 3'd1, 8'h77, 1'b0, 3'd0, 8'h00, 8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8};
    tbl[5] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0};
    tbl[6] = '{1'b0, 1'b1, 3'd5, 8'h55, 1'b1, 3'd7, 8'hBB, 8'hDF, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1};
    tbl[7] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'hBB, 8'h7F, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hBB, 1'b1, 1};

    // Reset values
    tick(); tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Table: one IDLE decision per vector, then settle back to IDLE.
    for (int v = 0; v < 8; v++) begin
      start[0] = tbl[v].start;
      a_req[0] = tbl[v].a_req; a_addr[0] = tbl[v].a_addr; a_data[0] = tbl[v].a_data;
      b_req[0] = tbl[v].b_req; b_addr[0] = tbl[v].b_addr; b_data[0] = tbl[v].b_data;
      tick();
      check($sformatf("vec%0d_load", v), 32'(ld8), 32'(tbl[v].ld));
      check($sformatf("vec%0d_clear", v), 32'(clr8), 32'(tbl[v].clr));
      check($sformatf("vec%0d_busy", v), 32'(busy[0]), 32'(tbl[v].busy));
      check($sformatf("vec%0d_ack_a", v), 32'(ack_a[0]), 32'(tbl[v].ack_a));
      check($sformatf("vec%0d_ack_b", v), 32'(ack_b[0]), 32'(tbl[v].ack_b));
      if (tbl[v].chk_data) check($sformatf("vec%0d_data", v), 32'(dbus[0]), 32'(tbl[v].data));
      drop_inputs();
      repeat (tbl[v].settle) tick();
      if (tbl[v].ack_a)
        check($sformatf("vec%0d_bank", v), 32'(bank0[tbl[v].a_addr]), 32'(tbl[v].a_data));
      if (tbl[v].ack_b)
        check($sformatf("vec%0d_bank", v), 32'(bank0[tbl[v].b_addr]), 32'(tbl[v].b_data));
    end

    // Clear sweep over a full bank, start and B request in the same cycle, restart ignored.
    bank_fill = 8'hFF; bank_wr_all = 1'b1; tick(); bank_wr_all = 1'b0;
    start[0] = 1'b1; b_req[0] = 1'b1; b_addr[0] = 3'd5; b_data[0] = 8'h3C;
    tick(); start[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("sweep_clear_k%0d", k), 32'(clr8), exp_vec(8, k));
      check($sformatf("sweep_busy_k%0d", k), 32'(busy[0]), 32'h1);
      check($sformatf("sweep_load_k%0d", k), 32'(ld8), 32'hFF);
      check($sformatf("sweep_ack_b_k%0d", k), 32'(ack_b[0]), 32'h0);
      start[0] = (k == 2);
      tick();
    end
    start[0] = 1'b0;
    check("sweep_end_busy", 32'(busy[0]), 32'h0);
    check("sweep_end_clear", 32'(clr8), 32'hFF);
    for (int r = 0; r < 8; r++) check($sformatf("sweep_bank%0d", r), 32'(bank0[r]), 32'h0);
    tick();
    check("held_b_ack", 32'(ack_b[0]), 32'h1);
    check("held_b_load", 32'(ld8), 32'hDF);
    b_req[0] = 1'b0;
    tick();
    check("held_b_bank5", 32'(bank0[5]), 32'h3C);
    check("restart_ignored_busy", 32'(busy[0]), 32'h0);
    check("restart_ignored_clear", 32'(clr8), 32'hFF);

    // Reset mid-sweep at k=3, then continuous contention: A first, strict alternation.
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    repeat (3) tick();
    check("midsweep_k3_clear", 32'(clr8), 32'hF7);
    rst_n = 1'b0; #1;
    chk_reset_vals("midsweep_rst");
    a_req[0] = 1'b1; a_addr[0] = 3'd1; a_data[0] = 8'hA1;
    b_req[0] = 1'b1; b_addr[0] = 3'd6; b_data[0] = 8'hB6;
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("rr_c%0d_ack_a", c), 32'(ack_a[0]), 32'(c % 4 == 1));
      check($sformatf("rr_c%0d_ack_b", c), 32'(ack_b[0]), 32'(c % 4 == 3));
      check($sformatf("rr_c%0d_load", c), 32'(ld8),
            (c % 4 == 1) ? 32'hFD : ((c % 4 == 3) ? 32'hBF : 32'hFF));
    end
    drop_inputs(); tick();

    // Out-of-range address on the 6-register instance.
    a_req[1] = 1'b1; a_addr[1] = 3'd7; a_data[1] = 8'h77;
    tick();
    check("badaddr_ack_a", 32'(ack_a[1]), 32'h1);
    check("badaddr_load", 32'(ld6), 32'h3F);
    check("badaddr_clear", 32'(clr6), 32'h3F);
    a_req[1] = 1'b0; tick();
    a_req[1] = 1'b1; a_addr[1] = 3'd1; a_data[1] = 8'h12;
    b_req[1] = 1'b1; b_addr[1] = 3'd2; b_data[1] = 8'h34;
    tick();
    check("badaddr_next_ack_b", 32'(ack_b[1]), 32'h1);
    check("badaddr_next_ack_a", 32'(ack_a[1]), 32'h0);
    check("badaddr_next_load", 32'(ld6), 32'h3B);
    drop_inputs(); tick();

    // Randomized run against the reference model.
    rst_n = 1'b0; bank_fill = 8'h00; bank_wr_all = 1'b1;
    tick();
    bank_wr_all = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mreset(i);
      for (int r = 0; r < 8; r++) exp_bank[i][r] = 0;
    end
    rst_n = 1'b1;
    repeat (1500) rcycle();
    tick();
    for (int r = 0; r < 8; r++) check($sformatf("rnd_bank0_%0d", r), 32'(bank0[r]), 32'(exp_bank[0][r]));
    for (int r = 0; r < 6; r++) check($sformatf("rnd_bank1_%0d", r), 32'(bank1[r]), 32'(exp_bank[1][r]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_regbank_arbiter.md
# sc_regbank_arbiter

Write-port controller for a bank of `SC_REGGENERAL` registers. It shares the bank between two requesters (A: game logic, B: scroll engine) and sequences a bank-wide clear sweep. It generates the per-register active-low `clear_InLow`/`load_InLow` strobes and the shared data bus. It sits between the game FSMs and the row-register bank that feeds the display path.

## Interface
Parameters:
- `DATAWIDTH`, 8, width of each bank register and of the request data.
- `NREGS`, 8, number of registers in the bank (2..16).
- `ADDRWIDTH`, 3, register-index width; must satisfy 2^ADDRWIDTH >= NREGS.

Ports:
- `SC_REGGENERAL_CLOCK_50`  in  1  system clock; all state on rising edge.
- `SC_REGGENERAL_RESET_InLow`  in  1  reset, asynchronous, active-low.
- `reqA_req`  in  1  requester A write request; level, held until ack.
- `reqA_addr`  in  ADDRWIDTH  target register index for A.
- `reqA_data`  in  DATAWIDTH  write data for A.
- `reqA_ack`  out  1  one-cycle pulse; A's write is issued.
- `reqB_req`, `reqB_addr`, `reqB_data`, `reqB_ack`  same as the A ports, for requester B.
- `clrAll_start`  in  1  pulse; request a clear sweep of the whole bank.
- `clrAll_busy`  out  1  high while the sweep runs.
- `bank_load_InLow`  out  NREGS  per-register load strobe; at most one bit low.
- `bank_clear_InLow`  out  NREGS  per-register clear strobe; at most one bit low.
- `bank_data_OutBUS`  out  DATAWIDTH  data shared by all bank registers.

## Operation
- States: IDLE, GNT_A, GNT_B, CLR.
- IDLE, evaluated in priority order:
  - `clrAll_start` → CLR with sweep index 0.
  - Else if both requests are pending → grant the requester selected by the round-robin pointer.
  - Else if one request is pending → grant that requester.
  - Else stay in IDLE.
- GNT_x, lasting exactly one cycle:
  - Drive `bank_load_InLow[addr]`=0 and `bank_data_OutBUS`=data, both latched when the grant was decided.
  - Pulse `reqx_ack`=1.
  - Set the pointer to the other requester.
  - Return to IDLE.
- Address `>= NREGS`: ack is still pulsed, no strobe is asserted, and the pointer still toggles.
- CLR, lasting NREGS cycles:
  - Drive `bank_clear_InLow[k]`=0 for k=0..NREGS-1, one register per cycle.
  - `clrAll_busy`=1 for the whole sweep.
  - After k=NREGS-1, return to IDLE.
- `clrAll_start` is ignored while in CLR or GNT_x. Requests stay pending and are served after the sweep.
- Outside GNT_x, `bank_data_OutBUS` holds its last value; its value is don't-care in CLR.
- Load and clear strobes are never asserted in the same cycle.
- Requesters must hold req, addr and data stable until ack. Dropping req early is a protocol violation; the latched write still issues.
- Reset mid-operation: the sweep or grant is abandoned. No completion is signalled.

## Timing
- Every output is registered.
- Reset values:
  - `bank_load_InLow` and `bank_clear_InLow` all 1s.
  - `bank_data_OutBUS`=0.
  - Acks and `clrAll_busy` = 0.
  - State IDLE, pointer = A.
- Write latency: req seen in IDLE at cycle n → strobe and ack in cycle n+1 → bank register shows the data from cycle n+2.
- Throughput: one write per 2 cycles. With both requesters continuously pending, grants alternate A, B, A, …
- Clear: start seen at cycle n → `clrAll_busy` high in cycles n+1..n+NREGS, and register k is cleared in cycle n+1+k.
  - IDLE at n+NREGS+1.
  - A request held through the sweep gets its strobe at n+NREGS+2.
- Start and request in the same IDLE cycle: the clear wins, and the request is held off.

## Structure
- Shared package `sc_regbank_pkg`:
  - State enum (IDLE, GNT_A, GNT_B, CLR).
  - Requester-select constants (REQ_A, REQ_B).
  - Default width parameters.
- One sub-module `sc_regbank_decoder`: index → active-low one-hot NREGS vector, with an enable. It is instantiated twice, once for load and once for clear.
- The top level holds the FSM, the round-robin pointer, the latched addr/data and the sweep counter (ADDRWIDTH bits).

## Test plan
- Reset: mid-sweep (k=3), assert reset → all strobes 1s next sample, busy=0, state IDLE. First A request afterwards is granted before B (pointer back to A).
- Single write: A req addr=2, data=0xA5 → `bank_load_InLow`=8'b11111011 and ack in cycle n+1. Register 2 reads 0xA5 at n+2; no other bit strobed.
- Contention: A and B both pending continuously with distinct addrs → grant order A, B, A, B, one ack every 2 cycles, no double ack.
- Clear sweep: start with all registers =0xFF → busy for 8 cycles, clear bit walks 0→7 one per cycle. All registers read 0 after the sweep, with no load strobes.
- Clear vs request: start and B req (addr 5, 0x3C) in the same cycle → sweep first. B ack at n+10, register 5 = 0x3C; second start during the sweep is ignored.
- Bad address: A addr=7 with NREGS=6 → ack pulses, no strobe; the next contended grant goes to B.
